// File: rtl/aes_pkg.sv
// Shared AES scheduler definitions: operand widths and
// the job FSM state encoding.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 128;

    localparam logic [1:0] SCHED_IDLE = 2'd0;
    localparam logic [1:0] SCHED_LOAD = 2'd1;
    localparam logic [1:0] SCHED_RUN  = 2'd2;
    localparam logic [1:0] SCHED_RESP = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = SCHED_IDLE,
        ST_LOAD = SCHED_LOAD,
        ST_RUN  = SCHED_RUN,
        ST_RESP = SCHED_RESP
    } sched_state_t;

endpackage

// File: rtl/aes_job_scheduler_if.sv
// Request, response and engine bundle of the AES job
// scheduler; slave is the scheduler side.
interface aes_job_scheduler_if
    import aes_pkg::*;
#(
    parameter int N_REQ = 4
);

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_ready;
    logic [AES_BLOCK_W*N_REQ-1:0] req_pt;
    logic [AES_KEY_W*N_REQ-1:0]   req_key;
    logic [N_REQ-1:0]             rsp_valid;
    logic [N_REQ-1:0]             rsp_ready;
    logic [AES_BLOCK_W-1:0]       rsp_ct;
    logic                         rsp_err;
    logic                         eng_start;
    logic [AES_BLOCK_W-1:0]       eng_pt;
    logic [AES_KEY_W-1:0]         eng_key;
    logic                         eng_done;
    logic [AES_BLOCK_W-1:0]       eng_ct;
    logic                         busy;

    modport slave (
        input  req_valid, req_pt, req_key,
        input  rsp_ready, eng_done, eng_ct,
        output req_ready, rsp_valid, rsp_ct, rsp_err,
        output eng_start, eng_pt, eng_key, busy
    );

    modport master (
        output req_valid, req_pt, req_key,
        output rsp_ready, eng_done, eng_ct,
        input  req_ready, rsp_valid, rsp_ct, rsp_err,
        input  eng_start, eng_pt, eng_key, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request
// at or above ptr, wrapping around.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_id
);

    always_comb begin
        int   idx;
        logic found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = W'(idx);
            end
        end
    end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one iterative AES-128 engine among N_REQ
// requesters with round-robin grant and a RUN watchdog.
module aes_job_scheduler
    import aes_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 rst_n,
    aes_job_scheduler_if.slave  bus
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    sched_state_t state, state_nxt;

    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          gnt_id;
    logic [IW-1:0]          arb_id;
    logic [N_REQ-1:0]       arb_gnt;
    logic [CW-1:0]          cnt;
    logic [AES_BLOCK_W-1:0] eng_pt_q;
    logic [AES_KEY_W-1:0]   eng_key_q;
    logic [AES_BLOCK_W-1:0] rsp_ct_q;
    logic                   rsp_err_q;
    logic                   accept;
    logic                   run_to;
    logic                   rsp_hs;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req    (bus.req_valid),
        .ptr    (rr_ptr),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    assign accept = (state == ST_IDLE) && |bus.req_valid;
    assign run_to = (cnt == CW'(TIMEOUT - 1));
    assign rsp_hs = (state == ST_RESP) && bus.rsp_ready[gnt_id];

    assign bus.eng_pt  = eng_pt_q;
    assign bus.eng_key = eng_key_q;
    assign bus.rsp_ct  = rsp_ct_q;
    assign bus.rsp_err = rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.eng_start = 1'b0;
        bus.busy      = (state != ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                bus.req_ready = arb_gnt;
                if (accept) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                bus.eng_start = 1'b1;
                state_nxt     = ST_RUN;
            end
            ST_RUN: begin
                if (bus.eng_done || run_to)
                    state_nxt = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = N_REQ'(1) << gnt_id;
                if (rsp_hs) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // eng_done outside RUN falls through untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            gnt_id    <= '0;
            cnt       <= '0;
            eng_pt_q  <= '0;
            eng_key_q <= '0;
            rsp_ct_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        eng_pt_q  <= bus.req_pt[AES_BLOCK_W*arb_id +: AES_BLOCK_W];
                        eng_key_q <= bus.req_key[AES_KEY_W*arb_id +: AES_KEY_W];
                        gnt_id    <= arb_id;
                    end
                end
                ST_LOAD: cnt <= '0;
                ST_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (bus.eng_done) begin
                        rsp_ct_q  <= bus.eng_ct;
                        rsp_err_q <= 1'b0;
                    end else if (run_to) begin
                        rsp_ct_q  <= '0;
                        rsp_err_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_hs)
                        rr_ptr <= (gnt_id == IW'(N_REQ - 1)) ?
                                  '0 : gnt_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/aes_job_scheduler.md
Name: aes_job_scheduler

Overview:
- Shares one iterative AES-128 encryption engine among N_REQ requesters.
- Round-robin arbitration picks one requester. The block captures that requester's plaintext and key, pulses the engine start, and waits for the engine's done pulse, with a watchdog timeout.
- The ciphertext goes back to the granting requester over a valid/ready response channel.
- Sits between the host-side request ports and the engine, and is the only block that drives the engine's operand and start inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 255, maximum RUN-state cycles before the job is aborted with an error (>= 64).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester job request
- req_ready  out  N_REQ  one-hot grant/accept; a job transfers when req_valid[i] & req_ready[i]
- req_pt  in  128*N_REQ  plaintext; requester i occupies bits [128*i +: 128]
- req_key  in  128*N_REQ  key; requester i occupies bits [128*i +: 128]
- rsp_valid  out  N_REQ  one-hot response valid
- rsp_ready  in  N_REQ  per-requester response accept
- rsp_ct  out  128  ciphertext of the current response
- rsp_err  out  1  current response is a timeout abort
- eng_start  out  1  one-cycle start pulse to the engine
- eng_pt  out  128  registered plaintext to the engine
- eng_key  out  128  registered key to the engine
- eng_done  in  1  engine completion pulse
- eng_ct  in  128  engine ciphertext, valid in the eng_done cycle
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - state = IDLE; rr_ptr = 0; gnt_id = 0; timeout counter = 0.
  - eng_start, req_ready, rsp_valid, rsp_err, busy = 0.
  - eng_pt, eng_key, rsp_ct = 0.
  - Reset asserted mid-job aborts the job silently: no response is produced and the engine outputs return to 0.
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - If any req_valid is high, pick the first set index searching from rr_ptr upward, with wrap-around.
  - req_ready[pick] = 1 combinationally in the same cycle; only one bit may ever be set.
  - On that edge, capture req_pt/req_key of the winner into eng_pt/eng_key, store gnt_id = pick, and go to LOAD.
  - req_ready is 0 in all other states, so no new job is accepted while one is in flight.
- LOAD: eng_start = 1 for exactly this cycle, counter cleared, then go to RUN.
- RUN:
  - The counter increments every cycle.
  - On eng_done: capture eng_ct into rsp_ct, set rsp_err = 0, go to RESP.
  - Else, when counter == TIMEOUT-1: set rsp_ct = 0, rsp_err = 1, go to RESP.
  - If eng_done and the timeout hit in the same cycle, done wins.
- eng_done in any state other than RUN is ignored and has no side effects.
- RESP:
  - rsp_valid[gnt_id] = 1; rsp_ct and rsp_err are held stable until rsp_ready[gnt_id].
  - rsp_ready on other indices is ignored.
  - On handshake: rr_ptr = (gnt_id + 1) mod N_REQ, go to IDLE.
- Latency: accept at edge 0; eng_start is high in cycle 1; the RESP cycle follows the eng_done edge. Best-case request-to-rsp_valid is engine latency + 2 cycles.
- Throughput: one job per (engine latency + 3) cycles; the IDLE bubble is kept deliberately.
- Fairness: with all requesters continuously valid, grants rotate 0, 1, ..., N_REQ-1, 0.
- Operands are captured at accept, so a requester may change req_pt/req_key or drop req_valid after its handshake.
- Counter width is clog2(TIMEOUT+1); the counter never wraps inside RUN.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W = 128, AES_KEY_W = 128.
  - FSM state encoding localparams: SCHED_IDLE, SCHED_LOAD, SCHED_RUN, SCHED_RESP.
- One sub-module, rr_arbiter:
  - Parameter N; inputs req[N] and ptr.
  - Combinational outputs: one-hot gnt[N] and index gnt_id.
  - Verified standalone as well.

Test Plan:
- Single job: req_valid = 4'b0010, FIPS-197 vector pt = 00112233445566778899aabbccddeeff, key = 000102030405060708090a0b0c0d0e0f, engine model.
  - Expect one eng_start pulse and eng_pt/eng_key equal to those values.
  - Expect rsp_valid = 4'b0010 with rsp_ct = 69c4e0d86a7b0430d8cdb78070b4c55a and rsp_err = 0.
- Round-robin: all four requesters continuously valid with rsp_ready = 1.
  - Grant order 0, 1, 2, 3, 0, 1.
  - No two req_ready bits high together; each response routed to the matching index.
- Backpressure: rsp_ready low for 10 cycles during RESP.
  - rsp_valid and rsp_ct stay stable, req_ready stays 0, no eng_start occurs.
  - Handshake completes one cycle after rsp_ready rises.
- Timeout: engine model never asserts eng_done.
  - Exactly TIMEOUT cycles in RUN, then rsp_err = 1 and rsp_ct = 0.
  - The next job still completes normally.
- Spurious/simultaneous events:
  - eng_done pulsed in IDLE and RESP: no state change.
  - eng_done on the same cycle as the timeout: rsp_err = 0 and ciphertext returned.
- Reset mid-RUN: all outputs return to reset values asynchronously, no rsp_valid is produced, and a new job after reset is granted to requester 0 first.
